sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO. Generalises the existing 8-bit × 16-entry synchronous FIFO with configurable width and depth, parameterised almost-full/almost-empty thresholds, an occupancy count, sticky error flags with explicit clear, and a synchronous flush. Used as the general-purpose buffering primitive between same-clock producer/consumer blocks.

---
 rtl/sync_fifo_param_if.sv | 32 +++
 rtl/sync_fifo_param.sv | 123 ++++++++++++
 tb/tb_sync_fifo_param.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Bus bundle for sync_fifo_param: producer/consumer handshake plus status.
// master = the block driving requests, slave = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              flush;
  logic              clr_err;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, flush, clr_err,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, flush, clr_err,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 4
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_param_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_TH);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic full, empty;
  logic rd_acc, wr_acc;
  logic mem_we;

`ifndef FIFO_FWFT_EN
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    rd_acc      = bus.rd_en & ~empty;
    // A read in the same cycle frees a slot, so a write at full still lands.
    wr_acc      = bus.wr_en & (~full | rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
`ifndef FIFO_FWFT_EN
    rd_data_d   = rd_data_q;
`endif

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we = wr_acc;
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
`ifndef FIFO_FWFT_EN
        rd_data_d = mem_q[rd_ptr_q];
`endif
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // Set terms are OR'd after the clear so a coincident set wins.
      overflow_d  = (overflow_q & ~bus.clr_err) | (bus.wr_en & full & ~rd_acc);
      underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd_en & empty);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifndef FIFO_FWFT_EN
      rd_data_q   <= '0;
`endif
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifndef FIFO_FWFT_EN
      rd_data_q   <= rd_data_d;
`endif
    end
  end

  // Storage has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

`ifdef FIFO_FWFT_EN
  assign bus.rd_data = mem_q[rd_ptr_q];
`else
  assign bus.rd_data = rd_data_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AFULL_CNT);
  assign bus.almost_empty = (count_q <= AEMPTY_CNT);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed vector table, hand sequences
// for fill/drain/wrap/flush, and randomized traffic against a queue-based model.
module tb_sync_fifo_param;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned AFULL_TH  = 12;
  localparam int unsigned AEMPTY_TH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus the architectural registers.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_rd  = '0;
  bit                m_ovf = 1'b0;
  bit                m_udf = 1'b0;

  typedef struct {
    bit r, w; logic [7:0] d; bit rd, f, c;
    int cnt; bit emp, ful, af, ae, ovf, udf; logic [7:0] rdv;
  } vec_t;
  vec_t vt[13];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(bit r, bit w, logic [7:0] d, bit rd, bit f, bit c);
    bit was_empty, was_full, racc, wacc;
    if (!r) begin
      mq.delete();
      m_rd = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (f) begin
      mq.delete();
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == int'(DEPTH));
      racc = rd && !was_empty;
      wacc = w && (!was_full || racc);
      m_ovf = (m_ovf && !c) || (w && was_full && !racc);
      m_udf = (m_udf && !c) || (rd && was_empty);
      if (racc) m_rd = mq.pop_front();
      if (wacc) mq.push_back(d);
    end
  endtask

  task automatic step(bit r, bit w, logic [7:0] d, bit rd, bit f, bit c);
    rst_n = r; bus.wr_en = w; bus.wr_data = d; bus.rd_en = rd;
    bus.flush = f; bus.clr_err = c;
    @(posedge clk);
    model(r, w, d, rd, f, c);
    #1;
  endtask

  task automatic check_model(string tag);
    int n;
    n = mq.size();
    check({tag, "_count"},  32'(bus.count),        32'(n));
    check({tag, "_empty"},  32'(bus.empty),        32'(n == 0));
    check({tag, "_full"},   32'(bus.full),         32'(n == int'(DEPTH)));
    check({tag, "_afull"},  32'(bus.almost_full),  32'(n >= int'(AFULL_TH)));
    check({tag, "_aempty"}, 32'(bus.almost_empty), 32'(n <= int'(AEMPTY_TH)));
    check({tag, "_ovf"},    32'(bus.overflow),     32'(m_ovf));
    check({tag, "_udf"},    32'(bus.underflow),    32'(m_udf));
`ifdef FIFO_FWFT_EN
    if (n != 0) check({tag, "_rdata"}, 32'(bus.rd_data), 32'(mq[0]));
`else
    check({tag, "_rdata"}, 32'(bus.rd_data), 32'(m_rd));
`endif
  endtask

  task automatic idle();
    step(1, 0, '0, 0, 0, 0);
  endtask

  initial begin
    bus.wr_en = 0; bus.wr_data = '0; bus.rd_en = 0; bus.flush = 0; bus.clr_err = 0;

    //            r w d     rd f c  cnt e f af ae ov ud rd
    vt[0]  = '{0,1,8'h11, 1,0,0,  0, 1,0,0,1, 0,0, 8'h00};
    vt[1]  = '{0,1,8'h11, 1,0,0,  0, 1,0,0,1, 0,0, 8'h00};
    vt[2]  = '{1,1,8'h5A, 1,0,0,  1, 0,0,0,1, 0,1, 8'h00};
    vt[3]  = '{1,0,8'h00, 1,0,0,  0, 1,0,0,1, 0,1, 8'h5A};
    vt[4]  = '{1,0,8'h00, 0,0,1,  0, 1,0,0,1, 0,0, 8'h5A};
    vt[5]  = '{1,0,8'h00, 1,0,1,  0, 1,0,0,1, 0,1, 8'h5A};
    vt[6]  = '{1,0,8'h00, 0,0,1,  0, 1,0,0,1, 0,0, 8'h5A};
    vt[7]  = '{1,1,8'h01, 0,0,0,  1, 0,0,0,1, 0,0, 8'h5A};
    vt[8]  = '{1,1,8'h02, 0,0,0,  2, 0,0,0,1, 0,0, 8'h5A};
    vt[9]  = '{1,1,8'h03, 1,1,0,  0, 1,0,0,1, 0,0, 8'h5A};
    vt[10] = '{1,0,8'h00, 1,1,0,  0, 1,0,0,1, 0,0, 8'h5A};
    vt[11] = '{1,1,8'h77, 0,0,0,  1, 0,0,0,1, 0,0, 8'h5A};
    vt[12] = '{1,0,8'h00, 1,0,0,  0, 1,0,0,1, 0,0, 8'h77};

    for (int k = 0; k < 13; k++) begin
      step(vt[k].r, vt[k].w, vt[k].d, vt[k].rd, vt[k].f, vt[k].c);
      check($sformatf("vec%0d_count", k),  32'(bus.count),        32'(vt[k].cnt));
      check($sformatf("vec%0d_empty", k),  32'(bus.empty),        32'(vt[k].emp));
      check($sformatf("vec%0d_full", k),   32'(bus.full),         32'(vt[k].ful));
      check($sformatf("vec%0d_afull", k),  32'(bus.almost_full),  32'(vt[k].af));
      check($sformatf("vec%0d_aempty", k), 32'(bus.almost_empty), 32'(vt[k].ae));
      check($sformatf("vec%0d_ovf", k),    32'(bus.overflow),     32'(vt[k].ovf));
      check($sformatf("vec%0d_udf", k),    32'(bus.underflow),    32'(vt[k].udf));
`ifndef FIFO_FWFT_EN
      check($sformatf("vec%0d_rdata", k),  32'(bus.rd_data),      32'(vt[k].rdv));
`endif
    end

    // Fill to full, then one rejected write.
    step(0, 0, '0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      step(1, 1, 8'(i), 0, 0, 0);
      check("fill_count",  32'(bus.count),        32'(i));
      check("fill_aempty", 32'(bus.almost_empty), 32'(i <= 4));
      check("fill_afull",  32'(bus.almost_full),  32'(i >= 12));
      check("fill_full",   32'(bus.full),         32'(i == 16));
    end
    step(1, 1, 8'hFF, 0, 0, 0);
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count),    32'd16);

    // Drain in order; the rejected 0xFF must never appear.
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      check("drain_head", 32'(bus.rd_data), 32'(i + 1));
`endif
      step(1, 0, '0, 1, 0, 0);
`ifndef FIFO_FWFT_EN
      check("drain_data", 32'(bus.rd_data), 32'(i + 1));
`endif
      check("drain_count", 32'(bus.count), 32'(15 - i));
    end
    check("drain_empty", 32'(bus.empty), 32'd1);
    step(1, 0, '0, 1, 0, 0);
    check("udf_set", 32'(bus.underflow), 32'd1);
    check("udf_ovf_kept", 32'(bus.overflow), 32'd1);
`ifndef FIFO_FWFT_EN
    check("udf_rd_hold", 32'(bus.rd_data), 32'h10);
`endif
    step(1, 0, '0, 0, 0, 1);
    check("clr_ovf", 32'(bus.overflow),  32'd0);
    check("clr_udf", 32'(bus.underflow), 32'd0);

    // Simultaneous read+write at full.
    for (int i = 1; i <= 16; i++) step(1, 1, 8'(i), 0, 0, 0);
    step(1, 1, 8'h20, 1, 0, 0);
    check("fullrw_count", 32'(bus.count),    32'd16);
    check("fullrw_ovf",   32'(bus.overflow), 32'd0);
`ifndef FIFO_FWFT_EN
    check("fullrw_rdata", 32'(bus.rd_data),  32'h01);
`endif
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      if (i == 15) check("fullrw_last", 32'(bus.rd_data), 32'h20);
`endif
      step(1, 0, '0, 1, 0, 0);
      check_model("fullrw_drain");
    end
`ifndef FIFO_FWFT_EN
    check("fullrw_last", 32'(bus.rd_data), 32'h20);
`endif

    // Simultaneous read+write at empty.
    step(1, 1, 8'h44, 1, 0, 0);
    check("emptyrw_count", 32'(bus.count),     32'd1);
    check("emptyrw_udf",   32'(bus.underflow), 32'd1);
    step(1, 0, '0, 1, 0, 1);
    check_model("emptyrw_pop");

    // Pointer wrap.
    step(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin step(1, 1, 8'(8'h80 + i), 0, 0, 0); check_model("wrap_w10"); end
    for (int i = 0; i < 10; i++) begin step(1, 0, '0, 1, 0, 0); check_model("wrap_r10"); end
    for (int i = 0; i < 16; i++) begin step(1, 1, 8'(8'h30 + i), 0, 0, 0); check_model("wrap_w16"); end
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      check("wrap_head", 32'(bus.rd_data), 32'(8'h30 + i));
`endif
      step(1, 0, '0, 1, 0, 0);
`ifndef FIFO_FWFT_EN
      check("wrap_data", 32'(bus.rd_data), 32'(8'h30 + i));
`endif
      check_model("wrap_r16");
    end

    // Flush at count 7 with a write pending; sticky underflow must survive.
    step(1, 0, '0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 8'(8'h60 + i), 0, 0, 0);
    check("preflush_count", 32'(bus.count), 32'd7);
    step(1, 1, 8'hEE, 0, 1, 0);
    check("flush_count", 32'(bus.count),     32'd0);
    check("flush_empty", 32'(bus.empty),     32'd1);
    check("flush_udf",   32'(bus.underflow), 32'd1);
    check("flush_ovf",   32'(bus.overflow),  32'd0);
    idle();
    check_model("postflush");

`ifdef FIFO_FWFT_EN
    step(1, 0, '0, 0, 0, 1);
    step(1, 1, 8'hA5, 0, 0, 0);
    check("fwft_show", 32'(bus.rd_data), 32'hA5);
    idle();
    check("fwft_hold", 32'(bus.rd_data), 32'hA5);
    step(1, 0, '0, 1, 0, 0);
    check("fwft_empty", 32'(bus.empty), 32'd1);
`endif

    // Randomized traffic; write bias alternates to visit both full and empty.
    step(0, 0, '0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit r, w, rd, f, c;
      int wp;
      wp = ((i / 300) % 2 == 0) ? 75 : 25;
      r  = ($urandom_range(0, 499) != 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      f  = ($urandom_range(0, 199) == 0);
      c  = ($urandom_range(0, 49) == 0);
      step(r, w, 8'($urandom), rd, f, c);
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
